// File: rtl/vram_write_arbiter.sv
// VRAM write-port arbiter: round-robin between requesters A/B plus a full-RAM clear sequencer.
// Latency: 1 clk acceptance->ram_we; ready is combinational and drops to 0 for both requesters while clearing.
module vram_write_arbiter #(
    parameter int addr_width = 10,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [addr_width-1:0] a_addr,
    input  logic [data_width-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_data,
    output logic                  b_ready,
    input  logic                  clear_start,
    input  logic [data_width-1:0] clear_value,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_d
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;
    localparam logic [addr_width-1:0] LAST_ADDR = {addr_width{1'b1}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  w_last_grant_nxt;
    logic [addr_width-1:0] r_cnt;
    logic [data_width-1:0] r_clear_value;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_clear_accept;
    logic                  w_clear_last;

    assign w_clear_last = (r_state == ST_CLEAR) && (r_cnt == LAST_ADDR);

    // last_grant only moves on contention; a lone requester does not disturb the rotation.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_grant_a        = 1'b0;
        w_grant_b        = 1'b0;
        w_clear_accept   = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (clear_start) begin
                    w_clear_accept = 1'b1;
                    w_state_nxt    = ST_CLEAR;
                end else if (a_valid && b_valid) begin
                    if (r_last_grant == GRANT_B) begin
                        w_grant_a        = 1'b1;
                        w_last_grant_nxt = GRANT_A;
                    end else begin
                        w_grant_b        = 1'b1;
                        w_last_grant_nxt = GRANT_B;
                    end
                end else if (a_valid) begin
                    w_grant_a = 1'b1;
                end else if (b_valid) begin
                    w_grant_b = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (w_clear_last) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;
    assign clear_busy = (r_state == ST_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_ARB;
            r_last_grant  <= GRANT_B;
            r_cnt         <= '0;
            r_clear_value <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            if (w_clear_accept) begin
                r_clear_value <= clear_value;
            end
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Write port registers; clear_done rides alongside the final fill write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_d      <= '0;
            clear_done <= 1'b0;
        end else begin
            ram_we     <= w_grant_a || w_grant_b || (r_state == ST_CLEAR);
            clear_done <= w_clear_last;
            if (w_grant_a) begin
                ram_addr <= a_addr;
                ram_d    <= a_data;
            end else if (w_grant_b) begin
                ram_addr <= b_addr;
                ram_d    <= b_data;
            end else if (r_state == ST_CLEAR) begin
                ram_addr <= r_cnt;
                ram_d    <= r_clear_value;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter (addr_width=4, data_width=8) with a write scoreboard.
module tb_vram_write_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic          clear_start = 1'b0;
    logic [DW-1:0] clear_value = '0;
    logic          clear_busy;
    logic          clear_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_writes = 0;
    int  n_dones  = 0;

    vram_write_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (clear_done) n_dones++;
            if (ram_we) begin
                wr_t e;
                n_writes++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%02h done=%0b, required no write",
                             ram_addr, ram_d, clear_done);
                end else begin
                    e = exp_q.pop_front();
                    if (ram_addr !== e.addr || ram_d !== e.data || clear_done !== e.done) begin
                        n_errors++;
                        $display("FAIL write: got addr=%0d data=%02h done=%0b, required addr=%0d data=%02h done=%0b",
                                 ram_addr, ram_d, clear_done, e.addr, e.data, e.done);
                    end
                end
            end else begin
                n_checks++;
                if (clear_done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL done_without_write: got clear_done=%0b, required 0", clear_done);
                end
            end
        end
    end

    task automatic push_clear(input logic [DW-1:0] v);
        for (int k = 0; k < 16; k++) begin
            wr_t e;
            e.addr = AW'(k);
            e.data = v;
            e.done = (k == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] ad, input logic [DW-1:0] d);
        wr_t e;
        e.addr = ad;
        e.data = d;
        e.done = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; clear_start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({a_ready, b_ready, clear_busy, clear_done, ram_we, ram_addr, ram_d} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got ready=%0b%0b busy=%0b done=%0b we=%0b addr=%0d d=%02h, required all 0",
                     a_ready, b_ready, clear_busy, clear_done, ram_we, ram_addr, ram_d);
        end
    endtask

    task automatic test_single();
        do_reset();
        a_valid = 1'b1; a_addr = 4'd3; a_data = 8'h5A;
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL single_a_ready: got a=%0b b=%0b, required a=1 b=0", a_ready, b_ready);
        end
        push_wr(4'd3, 8'h5A);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 4'd12; b_data = 8'hC3;
        #1;
        n_checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL single_b_ready: got a=%0b b=%0b, required a=0 b=1", a_ready, b_ready);
        end
        push_wr(4'd12, 8'hC3);
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL single_idle: got we=%0b pending=%0d, required we=0 pending=0", ram_we, exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        do_reset();
        a_valid = 1'b1; a_addr = 4'd1; a_data = 8'hA0;
        b_valid = 1'b1; b_addr = 4'd8; b_data = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_a = (i % 2 == 0);
            n_checks++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                n_errors++;
                $display("FAIL rr_grant%0d: got a=%0b b=%0b, required a=%0b b=%0b",
                         i, a_ready, b_ready, exp_a, !exp_a);
            end
            if (exp_a) push_wr(a_addr, a_data);
            else       push_wr(b_addr, b_data);
            @(negedge clk);
            if (exp_a) begin a_addr = a_addr + 4'd1; a_data = a_data + 8'h01; end
            else       begin b_addr = b_addr + 4'd1; b_data = b_data + 8'h01; end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rr_drain: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    // Covers both the plain fill and a requester held off across the whole clear.
    task automatic test_clear_with_a();
        int w0, d0;
        do_reset();
        w0 = n_writes; d0 = n_dones;
        clear_start = 1'b1; clear_value = 8'hFF;
        a_valid = 1'b1; a_addr = 4'd9; a_data = 8'h33;
        #1;
        n_checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_start_ready: got a=%0b b=%0b, required 0 0", a_ready, b_ready);
        end
        push_clear(8'hFF);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            clear_start = 1'b0; clear_value = 8'h00;
            #1;
            n_checks++;
            if (clear_busy !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL clear_busy_cyc%0d: got busy=%0b a=%0b b=%0b, required busy=1 a=0 b=0",
                         i, clear_busy, a_ready, b_ready);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (clear_busy !== 1'b0 || a_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_end_grant: got busy=%0b a_ready=%0b, required busy=0 a_ready=1", clear_busy, a_ready);
        end
        push_wr(4'd9, 8'h33);
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (n_writes - w0 != 17 || n_dones - d0 != 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL clear_totals: got writes=%0d dones=%0d pending=%0d, required 17 1 0",
                     n_writes - w0, n_dones - d0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_clear();
        int d0, w0;
        do_reset();
        d0 = n_dones; w0 = n_writes;
        clear_start = 1'b1; clear_value = 8'h6C;
        push_clear(8'h6C);
        @(negedge clk);
        clear_start = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ram_we, ram_addr, ram_d, clear_busy, clear_done, a_ready, b_ready} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: got we=%0b addr=%0d d=%02h busy=%0b done=%0b, required all 0",
                     ram_we, ram_addr, ram_d, clear_busy, clear_done);
        end
        n_checks++;
        if (n_writes - w0 != 8) begin
            n_errors++;
            $display("FAIL rst_mid_writes: got %0d writes before reset, required 8 (addr 0..7)", n_writes - w0);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_dones != d0 || clear_busy !== 1'b0 || ram_we !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_abort: got dones=%0d busy=%0b we=%0b, required dones=%0d busy=0 we=0",
                     n_dones - d0, clear_busy, ram_we, 0);
        end
        clear_start = 1'b1; clear_value = 8'h21;
        push_clear(8'h21);
        @(negedge clk);
        clear_start = 1'b0;
        repeat (18) @(negedge clk);
        n_checks++;
        if (n_dones - d0 != 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rst_restart: got dones=%0d pending=%0d, required 1 0", n_dones - d0, exp_q.size());
        end
    endtask

    task automatic test_clear_while_busy();
        int d0, w0;
        do_reset();
        d0 = n_dones; w0 = n_writes;
        clear_start = 1'b1; clear_value = 8'hA5;
        push_clear(8'hA5);
        @(negedge clk);
        clear_start = 1'b0;
        repeat (4) @(negedge clk);
        clear_start = 1'b1; clear_value = 8'h11;
        b_valid = 1'b1; b_addr = 4'd5; b_data = 8'h77;
        #1;
        n_checks++;
        if (b_ready !== 1'b0 || clear_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_restart_ready: got b_ready=%0b busy=%0b, required 0 1", b_ready, clear_busy);
        end
        @(negedge clk);
        clear_start = 1'b0; clear_value = 8'h00; b_valid = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++;
        if (n_writes - w0 != 16 || n_dones - d0 != 1 || exp_q.size() != 0 || clear_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_restart_totals: got writes=%0d dones=%0d pending=%0d busy=%0b, required 16 1 0 0",
                     n_writes - w0, n_dones - d0, exp_q.size(), clear_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_clear_with_a();
        test_reset_mid_clear();
        test_clear_while_busy();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
